// File: rtl/pc_gen_ras.sv
// Fetch-address generator with a small circular return-address stack.
// Holds the fetch PC, applies trap/redirect/stall/return-prediction priority,
// and rejects misaligned redirect targets with a one-cycle error pulse.
module pc_gen_ras #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            stall,
  input  logic                            trap_en,
  input  logic [ADDR_WIDTH-1:0]           trap_vec,
  input  logic                            redirect_en,
  input  logic [ADDR_WIDTH-1:0]           redirect_target,
  input  logic                            push_en,
  input  logic [ADDR_WIDTH-1:0]           push_addr,
  input  logic                            ret_pred,
  output logic [ADDR_WIDTH-1:0]           pc_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0]  ras_count,
  output logic                            ras_empty,
  output logic                            ras_full,
  output logic                            misalign_err
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = $clog2(RAS_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_p0;
  logic [CW-1:0]         ras_cnt_p0;
  logic [PW-1:0]         ras_top_p0;
  logic                  misalign_p0;
  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic                  misalign;
  logic                  redirect_ok;
  logic                  pop_ok;
  logic                  push_ok;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic [CW-1:0]         cnt_nxt;
  logic [PW-1:0]         top_nxt;
  logic                  wr_en;
  logic [PW-1:0]         wr_idx;

  // Next-PC priority and RAS pointer/count bookkeeping for this cycle.
  always_comb begin
    misalign    = redirect_en && (redirect_target[1:0] != 2'b00) && !trap_en;
    redirect_ok = redirect_en && (redirect_target[1:0] == 2'b00) && !trap_en;
    // Any redirect (good or rejected) and any stall suppress the return prediction.
    pop_ok      = ret_pred && (ras_cnt_p0 != '0) && !trap_en && !redirect_en && !stall;
    push_ok     = push_en && !trap_en && !misalign;
    pc_nxt      = pc_p0 + ADDR_WIDTH'(4);
    cnt_nxt     = ras_cnt_p0;
    top_nxt     = ras_top_p0;
    wr_en       = 1'b0;
    wr_idx      = ras_top_p0 + PW'(1);

    if (trap_en)          pc_nxt = trap_vec;
    else if (misalign)    pc_nxt = pc_p0;
    else if (redirect_ok) pc_nxt = redirect_target;
    else if (stall)       pc_nxt = pc_p0;
    else if (pop_ok)      pc_nxt = ras_mem[ras_top_p0];

    if (trap_en) begin
      cnt_nxt = '0;
      top_nxt = '0;
    end else if (push_ok && pop_ok) begin
      // Return consumes the old top while the call's address takes its slot.
      wr_en  = 1'b1;
      wr_idx = ras_top_p0;
    end else if (push_ok) begin
      wr_en   = 1'b1;
      top_nxt = ras_top_p0 + PW'(1);
      if (ras_cnt_p0 != CW'(RAS_DEPTH)) cnt_nxt = ras_cnt_p0 + CW'(1);
    end else if (pop_ok) begin
      top_nxt = ras_top_p0 - PW'(1);
      cnt_nxt = ras_cnt_p0 - CW'(1);
    end
  end

  // Control state: PC, RAS pointer/count and the error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0       <= RESET_VECTOR;
      ras_cnt_p0  <= '0;
      ras_top_p0  <= '0;
      misalign_p0 <= 1'b0;
    end else begin
      pc_p0       <= pc_nxt;
      ras_cnt_p0  <= cnt_nxt;
      ras_top_p0  <= top_nxt;
      misalign_p0 <= misalign;
    end
  end

  // RAS storage; entries are only readable once count covers them, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) ras_mem[wr_idx] <= push_addr;
  end

  assign pc_out       = pc_p0;
  assign ras_count    = ras_cnt_p0;
  assign ras_empty    = (ras_cnt_p0 == '0);
  assign ras_full     = (ras_cnt_p0 == CW'(RAS_DEPTH));
  assign misalign_err = misalign_p0;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Bench for pc_gen_ras: directed literal scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_pc_gen_ras;

  localparam int          AW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, trap_en = 1'b0, redirect_en = 1'b0, push_en = 1'b0, ret_pred = 1'b0;
  logic [31:0] trap_vec = '0, redirect_target = '0, push_addr = '0;
  logic [31:0] pc_out;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, misalign_err;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_pc  = RV;
  logic        m_err = 1'b0;
  logic [31:0] m_q[$];

  pc_gen_ras #(.ADDR_WIDTH(AW), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .trap_en(trap_en), .trap_vec(trap_vec),
    .redirect_en(redirect_en), .redirect_target(redirect_target),
    .push_en(push_en), .push_addr(push_addr), .ret_pred(ret_pred),
    .pc_out(pc_out), .ras_count(ras_count), .ras_empty(ras_empty),
    .ras_full(ras_full), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: apply the next-PC priority list and RAS rules at each rising edge
  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc  = RV;
      m_err = 1'b0;
      m_q.delete();
    end else begin
      logic mis, pop;
      logic [31:0] top;
      mis   = redirect_en && (redirect_target[1:0] != 0) && !trap_en;
      m_err = mis;
      if (trap_en) begin
        m_pc = trap_vec;
        m_q.delete();
      end else if (!mis) begin
        pop = !redirect_en && !stall && ret_pred && (m_q.size() > 0);
        top = (m_q.size() > 0) ? m_q[$] : 32'h0;
        if (redirect_en)  m_pc = redirect_target;
        else if (stall)   m_pc = m_pc;
        else if (pop)     m_pc = top;
        else              m_pc = m_pc + 32'd4;
        if (push_en && pop) m_q[$] = push_addr;
        else if (push_en) begin
          m_q.push_back(push_addr);
          if (m_q.size() > DEPTH) void'(m_q.pop_front());
        end else if (pop) void'(m_q.pop_back());
      end
    end
  end

  // Compare DUT against the model on every falling edge outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_pc", pc_out, m_pc);
      chk("m_count", {29'd0, ras_count}, m_q.size());
      chk("m_empty", {31'd0, ras_empty}, {31'd0, m_q.size() == 0});
      chk("m_full", {31'd0, ras_full}, {31'd0, m_q.size() == DEPTH});
      chk("m_misalign", {31'd0, misalign_err}, {31'd0, m_err});
    end
  end

  task automatic idle();
    stall = 0; trap_en = 0; redirect_en = 0; push_en = 0; ret_pred = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pcs[4];
    // Reset state
    idle();
    @(posedge clk); #1;
    chk("rst_pc", pc_out, 32'h100);
    chk("rst_count", {29'd0, ras_count}, 32'd0);
    chk("rst_empty", {31'd0, ras_empty}, 32'd1);
    chk("rst_full", {31'd0, ras_full}, 32'd0);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);
    @(negedge clk); rst_n = 1;

    // Free-running sequence from the reset vector
    cyc(); chk("seq1", pc_out, 32'h104);
    cyc(); chk("seq2", pc_out, 32'h108);
    cyc(); chk("seq3", pc_out, 32'h10C);

    // Redirect beats stall, then stall holds
    stall = 1; redirect_en = 1; redirect_target = 32'h200;
    cyc(); chk("redir_over_stall", pc_out, 32'h200);
    redirect_en = 0;
    cyc(); chk("stall_hold", pc_out, 32'h200);
    idle();

    // Misaligned redirect rejected with a one-cycle pulse
    redirect_en = 1; redirect_target = 32'h202;
    cyc(); chk("mis_pc", pc_out, 32'h200); chk("mis_err", {31'd0, misalign_err}, 32'd1);
    idle();
    cyc(); chk("mis_err_drop", {31'd0, misalign_err}, 32'd0); chk("mis_after", pc_out, 32'h204);
    redirect_en = 1; redirect_target = 32'h202; trap_en = 1; trap_vec = 32'h80;
    cyc(); chk("trap_pc", pc_out, 32'h80); chk("trap_no_err", {31'd0, misalign_err}, 32'd0);
    idle();

    // Fill RAS past capacity, then drain it
    for (int i = 1; i <= 5; i++) begin
      push_en = 1; push_addr = 32'(i * 16);
      cyc();
    end
    idle();
    chk("full_flag", {31'd0, ras_full}, 32'd1);
    chk("full_count", {29'd0, ras_count}, 32'd4);
    pcs = '{32'h50, 32'h40, 32'h30, 32'h20};
    ret_pred = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("pop_pc", pc_out, pcs[i]);
    end
    cyc(); chk("pop_empty_pc", pc_out, 32'h24); chk("pop_empty_cnt", {29'd0, ras_count}, 32'd0);
    idle();

    // Simultaneous push and pop replaces the top
    for (int i = 1; i <= 4; i++) begin
      push_en = 1; push_addr = 32'(i * 16);
      cyc();
    end
    push_en = 1; push_addr = 32'h99; ret_pred = 1;
    cyc(); chk("pp_pc", pc_out, 32'h40); chk("pp_count", {29'd0, ras_count}, 32'd4);
    push_en = 0;
    cyc(); chk("pp_next", pc_out, 32'h99);
    idle(); trap_en = 1; trap_vec = 32'h80; push_en = 1; push_addr = 32'h77;
    cyc(); chk("trap_clear", {29'd0, ras_count}, 32'd0); chk("trap_pc2", pc_out, 32'h80);
    idle();

    // PC wraps modulo 2^32
    redirect_en = 1; redirect_target = 32'hFFFF_FFFC;
    cyc(); idle();
    cyc(); chk("wrap", pc_out, 32'h0);

    // Asynchronous reset mid-cycle with a pending push
    push_en = 1; push_addr = 32'h55;
    @(posedge clk); #2 rst_n = 0; #1;
    chk("async_pc", pc_out, 32'h100);
    chk("async_cnt", {29'd0, ras_count}, 32'd0);
    idle();
    @(posedge clk); @(negedge clk); rst_n = 1;
    cyc(); chk("post_rst", pc_out, 32'h104);

    // Randomized traffic checked by the model
    for (int n = 0; n < 600; n++) begin
      stall       = ($urandom_range(0, 4) == 0);
      trap_en     = ($urandom_range(0, 40) == 0);
      trap_vec    = {$urandom(), 2'b00} >> 0;
      trap_vec[1:0] = 2'b00;
      redirect_en = ($urandom_range(0, 6) == 0);
      redirect_target = $urandom();
      if ($urandom_range(0, 3) != 0) redirect_target[1:0] = 2'b00;
      push_en     = ($urandom_range(0, 2) == 0);
      push_addr   = $urandom();
      ret_pred    = ($urandom_range(0, 2) == 0);
      cyc();
    end
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen_ras.md
# pc_gen_ras

Parametrised fetch-address generator for the 5-stage pipeline: the next generation of the plain PC register. It holds the fetch PC and adds a configurable reset vector, stall, trap vectoring and prioritised redirects. A small circular return-address stack (RAS) predicts return targets in IF. Misaligned redirect targets are rejected, not loaded. Sits at the front of IF and drives the instruction-memory address.

## Interface
- ADDR_WIDTH, 32: width of all addresses.
- RESET_VECTOR, 0: PC value loaded on reset; must be a multiple of 4.
- RAS_DEPTH, 4: RAS entries; power of two, ≥2.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- stall  in  1  hold PC (hazard unit).
- trap_en  in  1  take trap; highest priority.
- trap_vec  in  ADDR_WIDTH  trap handler address.
- redirect_en  in  1  resolved branch/jump from EX.
- redirect_target  in  ADDR_WIDTH  ALU-computed target.
- push_en  in  1  call retired in EX: push push_addr.
- push_addr  in  ADDR_WIDTH  return address (call PC+4).
- ret_pred  in  1  IF decoded a return: predict from RAS.
- pc_out  out  ADDR_WIDTH  current fetch PC, registered.
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries.
- ras_empty / ras_full  out  1 each  ras_count==0 / ras_count==RAS_DEPTH.
- misalign_err  out  1  one-cycle pulse: rejected misaligned redirect.

## Operation
- Next-PC priority, evaluated each cycle:
  1. trap_en: PC ← trap_vec.
  2. redirect_en with redirect_target[1:0]==0: PC ← redirect_target.
  3. stall: PC holds.
  4. ret_pred with RAS non-empty: PC ← RAS top, pop.
  5. Otherwise: PC ← PC+4.
- Misaligned redirect (redirect_en, target[1:0]≠0, no trap):
  - PC holds.
  - misalign_err=1 on the next cycle.
  - Push, pop and stall are ignored for that cycle.
- ret_pred with RAS empty: sequential PC+4; count stays 0.
- ret_pred under stall, redirect or trap: no pop.
- PC arithmetic is modulo 2^ADDR_WIDTH; 0xFFFF_FFFC+4 wraps to 0.
- RAS is circular: top pointer plus saturating count.
  - Push: write at top+1, advance top, count+1, saturating at RAS_DEPTH.
  - Push when full overwrites the oldest entry.
  - Pop: read top, decrement top, count−1.
- Push honoured regardless of stall or valid redirect.
- Push and pop in the same cycle: top entry replaced by push_addr; pointer and count unchanged. Returns the pre-push top as predicted PC.
- trap_en clears RAS (count←0, top←0) and discards any same-cycle push.

## Timing
- Reset (asynchronous assert; synchronous-release usage):
  - pc_out=RESET_VECTOR, ras_count=0, ras_empty=1, ras_full=0, misalign_err=0.
  - RAS contents undefined, never observable.
- pc_out, ras_* and misalign_err are all registered. Every input affects outputs exactly one clock edge later; no combinational input-to-output path.
- Reset asserted mid-operation discards pending redirect/push immediately; first post-reset edge applies normal rules from RESET_VECTOR.
- misalign_err is high for exactly one cycle per rejected redirect. Back-to-back rejects give back-to-back pulses.
- Single-cycle redirect penalty belongs to the pipeline; this block adds no bubbles.

## Test plan
- Reset with RESET_VECTOR=0x100, then 3 free cycles → pc_out 0x100, 0x104, 0x108, 0x10C; ras_empty=1.
- stall=1 with redirect_en=1, target=0x200, same cycle → pc_out=0x200 next cycle. Next cycle stall only → pc_out holds 0x200.
- redirect_target=0x202 → pc_out unchanged, misalign_err pulses one cycle. Same cycle trap_en, trap_vec=0x80 → pc_out=0x80, no misalign_err.
- RAS_DEPTH=4: push 0x10,0x20,0x30,0x40,0x50 → ras_full=1, count=4. Five ret_pred pops → PCs 0x50,0x40,0x30,0x20, then PC+4 (empty).
- Simultaneous push 0x99 and ret_pred with top 0x40 → pc_out=0x40, count unchanged, next pop yields 0x99. trap_en then clears count to 0.
- PC=0xFFFF_FFFC, free cycle → pc_out=0x0. rst_n pulsed low mid-cycle → pc_out=RESET_VECTOR immediately, without waiting for a clock edge.
